// File: rtl/cpu_txn_pkg.sv
// Shared types and constants for the per-CPU transaction generator.
// The LFSR step lives here so the generator and the LFSR agree on one polynomial.
package cpu_txn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } cpu_txn_state_e;

    typedef struct packed {
        logic [31:0] cpu_index;
        logic [31:0] seq;
    } cpu_txn_word_t;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [31:0] CHECKSUM_TAG = 32'hC5C5C5C5;

    // One Galois shift: shift right, fold the polynomial in when a one falls out.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/cpu_txn_lfsr.sv
// 16-bit Galois LFSR used to pick idle-gap lengths.
// rst loads the seed; a zero seed is replaced by 1 so the register never locks up.
module cpu_txn_lfsr
    import cpu_txn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/cpu_txn_gen.sv
// Per-CPU transaction source: NB_TRANSACTIONS words on valid/ready with LFSR-driven idle gaps.
// Define CPU_TXN_GEN_CHECKSUM_EN to append a {CHECKSUM_TAG, xor-of-seq} word before done.
//
// state | meaning
// IDLE  | first cycle out of reset: latch cpu_index, seed the LFSR
// SEND  | word presented, held stable until data_rdy
// GAP   | idle cycles between words, gap_cnt counts down
// DONE  | all words accepted, transactions_done held until reset
module cpu_txn_gen
    import cpu_txn_pkg::*;
#(
    parameter int unsigned NB_TRANSACTIONS = 100,
    parameter int unsigned GAP_MAX         = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_index,
    input  logic        data_rdy,
    output logic        data_vld,
    output logic [63:0] data,
    output logic        transactions_done,
    output logic [31:0] sent_count
);

    localparam logic [31:0] NB_W    = 32'(NB_TRANSACTIONS);
    localparam logic [31:0] GAP_DIV = 32'(GAP_MAX) + 32'd1;

    cpu_txn_state_e state;
    cpu_txn_word_t  word_q;
    cpu_txn_word_t  word_first;
    cpu_txn_word_t  word_cur;
    cpu_txn_word_t  word_inc;
    logic [31:0]    cpu_q;
    logic [31:0]    seq;
    logic [31:0]    seq_inc;
    logic [7:0]     gap_cnt;
    logic [7:0]     gap_next;
    logic           is_last;
    logic           lfsr_rst;
    logic           lfsr_step;
    logic [15:0]    lfsr_value;
    logic [7:0]     lfsr_unused;

    assign data      = word_q;
    assign seq_inc   = seq + 32'd1;
    assign lfsr_rst  = rst || (state == IDLE);
    assign lfsr_step = (state == SEND) && data_rdy;

    // Gap length comes from the LFSR value held at the accept, before it steps.
    assign gap_next    = 8'({24'd0, lfsr_value[7:0]} % GAP_DIV);
    assign lfsr_unused = lfsr_value[15:8];

`ifdef CPU_TXN_GEN_CHECKSUM_EN
    logic [31:0] csum;

    assign is_last    = (seq == NB_W);
    assign word_first = (NB_W == 32'd0) ? '{cpu_index: CHECKSUM_TAG, seq: 32'd0}
                                        : '{cpu_index: cpu_index, seq: 32'd0};
    assign word_cur   = (seq == NB_W) ? '{cpu_index: CHECKSUM_TAG, seq: csum}
                                      : '{cpu_index: cpu_q, seq: seq};
    assign word_inc   = (seq_inc == NB_W) ? '{cpu_index: CHECKSUM_TAG, seq: csum ^ seq}
                                          : '{cpu_index: cpu_q, seq: seq_inc};

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            csum <= 32'd0;
        end else if ((state == SEND) && data_rdy) begin
            csum <= csum ^ seq;
        end
    end
`else
    assign is_last    = (seq_inc == NB_W);
    assign word_first = '{cpu_index: cpu_index, seq: 32'd0};
    assign word_cur   = '{cpu_index: cpu_q, seq: seq};
    assign word_inc   = '{cpu_index: cpu_q, seq: seq_inc};
`endif

    cpu_txn_lfsr u_lfsr (
        .clk   (clk),
        .rst   (lfsr_rst),
        .seed  (LFSR_SEED ^ cpu_index[15:0]),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            word_q            <= '0;
            data_vld          <= 1'b0;
            transactions_done <= 1'b0;
            sent_count        <= 32'd0;
            seq               <= 32'd0;
            gap_cnt           <= 8'd0;
            cpu_q             <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_q <= cpu_index;
`ifdef CPU_TXN_GEN_CHECKSUM_EN
                    state    <= SEND;
                    data_vld <= 1'b1;
                    word_q   <= word_first;
`else
                    if (NB_W == 32'd0) begin
                        state             <= DONE;
                        transactions_done <= 1'b1;
                    end else begin
                        state    <= SEND;
                        data_vld <= 1'b1;
                        word_q   <= word_first;
                    end
`endif
                end
                SEND: begin
                    if (data_rdy) begin
                        sent_count <= (sent_count == '1) ? sent_count : sent_count + 32'd1;
                        seq        <= seq_inc;
                        if (is_last) begin
                            state             <= DONE;
                            data_vld          <= 1'b0;
                            transactions_done <= 1'b1;
                        end else if (gap_next == 8'd0) begin
                            word_q <= word_inc;
                        end else begin
                            state    <= GAP;
                            data_vld <= 1'b0;
                            gap_cnt  <= gap_next;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state    <= SEND;
                        data_vld <= 1'b1;
                        word_q   <= word_cur;
                    end
                end
                DONE: begin
                    transactions_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_txn_gen.sv
// Directed bench for cpu_txn_gen: back-to-back stream, stall, empty run, LFSR gaps, mid-stall reset.
// Honours CPU_TXN_GEN_CHECKSUM_EN by expecting the extra checksum word.
module tb_cpu_txn_gen;

`ifdef CPU_TXN_GEN_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic clk;
    int   errors = 0;
    int   checks = 0;

    logic        a_rst, a_rdy, a_vld, a_done;
    logic [31:0] a_idx, a_cnt;
    logic [63:0] a_data;
    logic        z_rst, z_rdy, z_vld, z_done;
    logic [31:0] z_idx, z_cnt;
    logic [63:0] z_data;
    logic        g_rst, g_rdy, g_vld, g_done;
    logic [31:0] g_idx, g_cnt;
    logic [63:0] g_data;

    cpu_txn_gen #(.NB_TRANSACTIONS(10), .GAP_MAX(0)) dut_a (
        .clk(clk), .rst(a_rst), .cpu_index(a_idx), .data_rdy(a_rdy),
        .data_vld(a_vld), .data(a_data), .transactions_done(a_done), .sent_count(a_cnt)
    );

    cpu_txn_gen #(.NB_TRANSACTIONS(0), .GAP_MAX(3)) dut_z (
        .clk(clk), .rst(z_rst), .cpu_index(z_idx), .data_rdy(z_rdy),
        .data_vld(z_vld), .data(z_data), .transactions_done(z_done), .sent_count(z_cnt)
    );

    cpu_txn_gen #(.NB_TRANSACTIONS(50), .GAP_MAX(3)) dut_g (
        .clk(clk), .rst(g_rst), .cpu_index(g_idx), .data_rdy(g_rdy),
        .data_vld(g_vld), .data(g_data), .transactions_done(g_done), .sent_count(g_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_word(input logic [31:0] idx, input int k, input int nb,
                                             input logic [31:0] x);
        return (CSUM != 0 && k == nb) ? {32'hC5C5C5C5, x} : {idx, 32'(k)};
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Checks words k0.. of dut_a one per cycle (rdy held high), then the DONE state.
    task automatic drain_a(input int k0, input logic [31:0] idx, input logic [31:0] x0);
        logic [31:0] x;
        x = x0;
        for (int k = k0; k < 10 + CSUM; k++) begin
            check("a_vld", 64'(a_vld), 64'(1));
            check("a_word", a_data, exp_word(idx, k, 10, x));
            if (k < 10) x = x ^ 32'(k);
            tick();
        end
        check("a_done", 64'(a_done), 64'(1));
        check("a_vld_done", 64'(a_vld), 64'(0));
        check("a_cnt", 64'(a_cnt), 64'(10 + CSUM));
        check("a_hold", a_data, exp_word(idx, 9 + CSUM, 10, x));
    endtask

    initial begin
        logic [15:0] lf;
        logic [31:0] x;
        int          idle;
        int          exp_gap;

        a_rst = 1'b1; a_rdy = 1'b1; a_idx = 32'd3;
        z_rst = 1'b1; z_rdy = 1'b1; z_idx = 32'd7;
        g_rst = 1'b1; g_rdy = 1'b1; g_idx = 32'h0000_1234;
        tick();
        tick();

        check("a_rst_vld", 64'(a_vld), 64'(0));
        check("a_rst_data", a_data, 64'd0);
        check("a_rst_done", 64'(a_done), 64'(0));
        check("a_rst_cnt", 64'(a_cnt), 64'(0));
        check("z_rst_done", 64'(z_done), 64'(0));

        // back-to-back stream, cpu_index 3
        a_rst = 1'b0;
        tick();
        drain_a(0, 32'd3, 32'd0);

        // word 1 stalled for 5 cycles
        a_rst = 1'b1; tick();
        a_rst = 1'b0; tick();
        check("st_w0", a_data, {32'd3, 32'd0});
        tick();
        check("st_w1", a_data, {32'd3, 32'd1});
        a_rdy = 1'b0;
        repeat (5) begin
            tick();
            check("st_vld", 64'(a_vld), 64'(1));
            check("st_data", a_data, {32'd3, 32'd1});
            check("st_cnt", 64'(a_cnt), 64'(1));
        end
        a_rdy = 1'b1;
        drain_a(1, 32'd3, 32'd0);

        // reset while word 7 is stalled; late cpu_index change is ignored until reset
        a_idx = 32'd5;
        a_rst = 1'b1; tick();
        a_rst = 1'b0; tick();
        check("rs_w0", a_data, {32'd5, 32'd0});
        a_idx = 32'd9;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("rs_word", a_data, {32'd5, 32'(k)});
        end
        a_rdy = 1'b0;
        tick();
        tick();
        check("rs_stall", a_data, {32'd5, 32'd7});
        a_rst = 1'b1;
        tick();
        check("rs_vld", 64'(a_vld), 64'(0));
        check("rs_cnt", 64'(a_cnt), 64'(0));
        check("rs_data", a_data, 64'd0);
        a_rst = 1'b0; a_rdy = 1'b1;
        tick();
        check("rs_re_vld", 64'(a_vld), 64'(1));
        check("rs_re_w0", a_data, {32'd9, 32'd0});
        tick();
        check("rs_re_w1", a_data, {32'd9, 32'd1});
        check("rs_re_cnt", 64'(a_cnt), 64'(1));

        // NB_TRANSACTIONS = 0
        z_rst = 1'b0;
        tick();
`ifdef CPU_TXN_GEN_CHECKSUM_EN
        check("z_csum_vld", 64'(z_vld), 64'(1));
        check("z_csum_word", z_data, {32'hC5C5C5C5, 32'd0});
        tick();
`endif
        check("z_done", 64'(z_done), 64'(1));
        repeat (3) begin
            check("z_vld", 64'(z_vld), 64'(0));
            check("z_cnt", 64'(z_cnt), 64'(CSUM));
            tick();
        end
        check("z_done_sticky", 64'(z_done), 64'(1));

        // 50 words with LFSR gaps, compared against an independent LFSR model
        lf = 16'hACE1 ^ 16'h1234;
        x = 32'd0;
        exp_gap = 0;
        g_rst = 1'b0;
        tick();
        for (int k = 0; k < 50 + CSUM; k++) begin
            idle = 0;
            while (g_vld !== 1'b1 && idle < 8) begin
                tick();
                idle++;
            end
            check("g_gap", 64'(idle), 64'(exp_gap));
            check("g_word", g_data, exp_word(32'h1234, k, 50, x));
            if (k < 50) x = x ^ 32'(k);
            exp_gap = int'(lf[7:0]) % 4;
            lf = ref_step(lf);
            tick();
        end
        check("g_done", 64'(g_done), 64'(1));
        check("g_cnt", 64'(g_cnt), 64'(50 + CSUM));
        check("g_vld_done", 64'(g_vld), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
